// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises reset release to clk, stretches it, then releases mem_rst_n and core_rst_n in turn.
// Latency: mem_rst_n rises after edge SYNC_STAGES+HOLD_CYCLES and core_rst_n STAGGER_CYCLES edges later; all outputs are registered.
// Backpressure: none; soft_rst_req is a level held by the requester and is acknowledged only in RUN.
//
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   soft_rst_req  - held-level soft reset request; soft_rst_ack pulses for one cycle on acceptance
//   wdt_kick      - watchdog refresh (only used when RST_SEQ_WDT_EN is defined)
//   mem_rst_n     - active-low reset to the memory/bus subsystem (released first)
//   core_rst_n    - active-low reset to the CPU core (released last)
//   rst_done      - high while in RUN
//   rst_cause     - last reset cause: 01 POR, 10 soft, 11 watchdog
//
// Optional feature: define RST_SEQ_WDT_EN to build the watchdog.
// Parameter limits: SYNC_STAGES >= 2, HOLD_CYCLES >= 1, STAGGER_CYCLES >= 1.

module rst_seq_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int WDT_CYCLES     = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst_req,
    output logic       soft_rst_ack,
    input  logic       wdt_kick,
    output logic       mem_rst_n,
    output logic       core_rst_n,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    localparam int MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_MAX = (MAX_HS > WDT_CYCLES) ? MAX_HS : WDT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    // The state register samples the last chain flop and acts as the final
    // synchroniser stage, so the chain itself is one flop shorter than
    // SYNC_STAGES. This puts the HOLD entry on edge SYNC_STAGES.
    localparam int SYNC_W = SYNC_STAGES - 1;

    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_MEM_REL = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYNC_W-1:0]  sync_q, sync_d;
    logic               mem_rst_n_q, mem_rst_n_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               rst_done_q, rst_done_d;
    logic               soft_rst_ack_q, soft_rst_ack_d;
    logic [1:0]         rst_cause_q, rst_cause_d;

`ifdef RST_SEQ_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LAST   = CNT_W'(WDT_CYCLES - 1);
    localparam logic [1:0]       CAUSE_WDT  = 2'b11;
`else
    logic unused_wdt_kick;
    assign unused_wdt_kick = wdt_kick;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_ASSERT;
            cnt_q          <= '0;
            sync_q         <= '1;
            mem_rst_n_q    <= 1'b0;
            core_rst_n_q   <= 1'b0;
            rst_done_q     <= 1'b0;
            soft_rst_ack_q <= 1'b0;
            rst_cause_q    <= CAUSE_POR;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync_q         <= sync_d;
            mem_rst_n_q    <= mem_rst_n_d;
            core_rst_n_q   <= core_rst_n_d;
            rst_done_q     <= rst_done_d;
            soft_rst_ack_q <= soft_rst_ack_d;
            rst_cause_q    <= rst_cause_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sync_d         = sync_q << 1;
        mem_rst_n_d    = mem_rst_n_q;
        core_rst_n_d   = core_rst_n_q;
        rst_done_d     = rst_done_q;
        soft_rst_ack_d = 1'b0;
        rst_cause_d    = rst_cause_q;

        case (state_q)
            ST_ASSERT: begin
                cnt_d = '0;
                if (!sync_q[SYNC_W-1]) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d     = ST_MEM_REL;
                    cnt_d       = '0;
                    mem_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEM_REL: begin
                if (cnt_q == STAGGER_LAST) begin
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                    core_rst_n_d = 1'b1;
                    rst_done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Soft request has priority over a coincident watchdog timeout.
                if (soft_rst_req) begin
                    state_d        = ST_HOLD;
                    cnt_d          = '0;
                    mem_rst_n_d    = 1'b0;
                    core_rst_n_d   = 1'b0;
                    rst_done_d     = 1'b0;
                    soft_rst_ack_d = 1'b1;
                    rst_cause_d    = CAUSE_SOFT;
                end
`ifdef RST_SEQ_WDT_EN
                // In RUN the shared counter is the watchdog counter.
                else if (wdt_kick) begin
                    cnt_d = '0;
                end else if (cnt_q == WDT_LAST) begin
                    state_d      = ST_HOLD;
                    cnt_d        = '0;
                    mem_rst_n_d  = 1'b0;
                    core_rst_n_d = 1'b0;
                    rst_done_d   = 1'b0;
                    rst_cause_d  = CAUSE_WDT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase
    end

    assign mem_rst_n    = mem_rst_n_q;
    assign core_rst_n   = core_rst_n_q;
    assign rst_done     = rst_done_q;
    assign soft_rst_ack = soft_rst_ack_q;
    assign rst_cause    = rst_cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with default timing parameters and WDT_CYCLES=8.
// Edges are counted from the first rising clk edge after rst deasserts; outputs sampled 1ns after the edge.
// The watchdog section is built only when RST_SEQ_WDT_EN is defined; otherwise absence of watchdog resets is checked.

module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       soft_rst_req;
    logic       soft_rst_ack;
    logic       wdt_kick;
    logic       mem_rst_n;
    logic       core_rst_n;
    logic       rst_done;
    logic [1:0] rst_cause;

    int checks;
    int errors;
    int acks_seen;
    int drops_seen;

    rst_seq_ctrl #(
        .SYNC_STAGES    (2),
        .HOLD_CYCLES    (16),
        .STAGGER_CYCLES (4),
        .WDT_CYCLES     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .wdt_kick     (wdt_kick),
        .mem_rst_n    (mem_rst_n),
        .core_rst_n   (core_rst_n),
        .rst_done     (rst_done),
        .rst_cause    (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        soft_rst_req = 1'b0;
        wdt_kick     = 1'b0;

        // Power-on reset values.
        tick(3);
        chk("por_mem_rst_n",  {1'b0, mem_rst_n},    2'd0);
        chk("por_core_rst_n", {1'b0, core_rst_n},   2'd0);
        chk("por_rst_done",   {1'b0, rst_done},     2'd0);
        chk("por_ack",        {1'b0, soft_rst_ack}, 2'd0);
        chk("por_cause",      rst_cause,            2'b01);

        // Release: mem after edge 18, core/done after edge 22.
        rst = 1'b0;
        tick(17);
        chk("por_mem_e17",    {1'b0, mem_rst_n},  2'd0);
        tick(1);
        chk("por_mem_e18",    {1'b0, mem_rst_n},  2'd1);
        chk("por_core_e18",   {1'b0, core_rst_n}, 2'd0);
        tick(3);
        chk("por_core_e21",   {1'b0, core_rst_n}, 2'd0);
        tick(1);
        chk("por_core_e22",   {1'b0, core_rst_n}, 2'd1);
        chk("por_done_e22",   {1'b0, rst_done},   2'd1);
        chk("por_cause_e22",  rst_cause,          2'b01);

        // Async abort during MEM_REL, then full sequence again.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(19);
        chk("abort_pre_mem",  {1'b0, mem_rst_n},  2'd1);
        chk("abort_pre_core", {1'b0, core_rst_n}, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_mem",      {1'b0, mem_rst_n},  2'd0);
        chk("abort_core",     {1'b0, core_rst_n}, 2'd0);
        chk("abort_done",     {1'b0, rst_done},   2'd0);
        chk("abort_cause",    rst_cause,          2'b01);
        tick(2);
        rst = 1'b0;
        tick(17);
        chk("rerun_mem_e17",  {1'b0, mem_rst_n},  2'd0);
        tick(1);
        chk("rerun_mem_e18",  {1'b0, mem_rst_n},  2'd1);
        tick(4);
        chk("rerun_core_e22", {1'b0, core_rst_n}, 2'd1);
        chk("rerun_done_e22", {1'b0, rst_done},   2'd1);

        // Soft reset in RUN sampled at edge k.
        soft_rst_req = 1'b1;
        tick(1);
        chk("soft_ack_k",     {1'b0, soft_rst_ack}, 2'd1);
        chk("soft_mem_k",     {1'b0, mem_rst_n},    2'd0);
        chk("soft_core_k",    {1'b0, core_rst_n},   2'd0);
        chk("soft_done_k",    {1'b0, rst_done},     2'd0);
        chk("soft_cause_k",   rst_cause,            2'b10);
        soft_rst_req = 1'b0;
        tick(1);
        chk("soft_ack_k1",    {1'b0, soft_rst_ack}, 2'd0);
        tick(14);
        chk("soft_mem_k15",   {1'b0, mem_rst_n},    2'd0);
        tick(1);
        chk("soft_mem_k16",   {1'b0, mem_rst_n},    2'd1);
        chk("soft_core_k16",  {1'b0, core_rst_n},   2'd0);
        tick(3);
        chk("soft_core_k19",  {1'b0, core_rst_n},   2'd0);
        tick(1);
        chk("soft_core_k20",  {1'b0, core_rst_n},   2'd1);
        chk("soft_done_k20",  {1'b0, rst_done},     2'd1);
        chk("soft_cause_k20", rst_cause,            2'b10);

        // Soft request raised during HOLD: acked only on the first RUN edge (23).
        rst = 1'b1;
        tick(1);
        chk("hold_req_cause_por", rst_cause, 2'b01);
        rst = 1'b0;
        tick(5);
        soft_rst_req = 1'b1;
        acks_seen = 0;
        repeat (17) begin
            tick(1);
            if (soft_rst_ack) acks_seen++;
        end
        chk("hold_req_no_early_ack", 2'(acks_seen),      2'd0);
        chk("hold_req_core_e22",     {1'b0, core_rst_n}, 2'd1);
        tick(1);
        chk("hold_req_ack_e23",      {1'b0, soft_rst_ack}, 2'd1);
        chk("hold_req_core_e23",     {1'b0, core_rst_n},   2'd0);
        chk("hold_req_cause_e23",    rst_cause,            2'b10);
        soft_rst_req = 1'b0;
        tick(1);
        chk("hold_req_ack_e24",      {1'b0, soft_rst_ack}, 2'd0);
        tick(14);
        chk("hold_req_mem_e38",      {1'b0, mem_rst_n},    2'd0);
        tick(1);
        chk("hold_req_mem_e39",      {1'b0, mem_rst_n},    2'd1);
        tick(4);
        chk("hold_req_core_e43",     {1'b0, core_rst_n},   2'd1);

`ifdef RST_SEQ_WDT_EN
        // No kicks: timeout on the 8th RUN edge.
        wdt_kick = 1'b0;
        tick(7);
        chk("wdt_done_7th",   {1'b0, rst_done},     2'd1);
        tick(1);
        chk("wdt_done_8th",   {1'b0, rst_done},     2'd0);
        chk("wdt_mem_8th",    {1'b0, mem_rst_n},    2'd0);
        chk("wdt_ack_8th",    {1'b0, soft_rst_ack}, 2'd0);
        chk("wdt_cause_8th",  rst_cause,            2'b11);
        tick(19);
        chk("wdt_rerun_e19",  {1'b0, rst_done},     2'd0);
        tick(1);
        chk("wdt_rerun_e20",  {1'b0, rst_done},     2'd1);

        // Kick every 5 cycles: no timeout over 100 cycles.
        drops_seen = 0;
        for (int i = 0; i < 100; i++) begin
            wdt_kick = ((i % 5) == 0);
            tick(1);
            if (!rst_done) drops_seen++;
        end
        chk("wdt_kicked_no_reset", 2'(drops_seen), 2'd0);

        // Timeout edge coincident with a soft request: soft wins.
        wdt_kick = 1'b1;
        tick(1);
        wdt_kick = 1'b0;
        tick(7);
        chk("wdt_coinc_pre_done", {1'b0, rst_done}, 2'd1);
        soft_rst_req = 1'b1;
        tick(1);
        chk("wdt_coinc_ack",   {1'b0, soft_rst_ack}, 2'd1);
        chk("wdt_coinc_cause", rst_cause,            2'b10);
        chk("wdt_coinc_done",  {1'b0, rst_done},     2'd0);
        soft_rst_req = 1'b0;
`else
        // Watchdog not built: unkicked RUN must stay up.
        wdt_kick   = 1'b0;
        drops_seen = 0;
        repeat (40) begin
            tick(1);
            if (!rst_done) drops_seen++;
        end
        chk("nowdt_no_reset", 2'(drops_seen), 2'd0);
        chk("nowdt_cause",    rst_cause,      2'b10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
